// File: rtl/itcm_loader.sv
// itcm_loader: streams a boot image into ITCM, optionally verifies it by checksum, and holds the CPU until it is good
module itcm_loader #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   word_cnt,
  input  logic          verify_en,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          itcm_ram_we,
  output logic [AW-1:0] itcm_ram_addr,
  output logic [DW-1:0] itcm_ram_din,
  output logic          itcm_ram_wem,
  input  logic [DW-1:0] itcm_ram_dout,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);
  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, DRAIN, CHECK, DONE, ERR} state_t;
  state_t        state;
  logic [AW-1:0] base;
  logic [AW:0]   cnt, wr_ptr, rd_ptr, last;
  logic          ver, rd_vld, go;
  logic [DW-1:0] load_sum, read_sum;
  assign go   = start && (state == IDLE || state == DONE || state == ERR);
  assign last = cnt - (AW+1)'(1);
  // Sequencer: load, optional readback with one-cycle RAM latency, then checksum compare
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      cnt      <= '0;
      ver      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_vld   <= 1'b0;
      load_sum <= '0;
      read_sum <= '0;
    end else begin
      rd_vld <= state == VERIFY;
      if (rd_vld) read_sum <= read_sum + itcm_ram_dout;
      if (go) begin
        base     <= base_addr;
        cnt      <= word_cnt;
        ver      <= verify_en;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        load_sum <= '0;
        read_sum <= '0;
        state    <= word_cnt == '0 ? DONE : LOAD;
      end else
        case (state)
          LOAD: if (s_valid) begin
            wr_ptr   <= wr_ptr + (AW+1)'(1);
            load_sum <= load_sum + s_data;
            if (wr_ptr == last) state <= ver ? VERIFY : DONE;
          end
          VERIFY: begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
            if (rd_ptr == last) state <= DRAIN;
          end
          DRAIN:   state <= CHECK;
          CHECK:   state <= read_sum == load_sum ? DONE : ERR;
          default: ;
        endcase
    end
  // RAM port and status decode; only the LOAD write path depends on s_valid
  always_comb begin
    s_ready       = state == LOAD;
    itcm_ram_we   = s_ready && s_valid;
    itcm_ram_wem  = itcm_ram_we;
    itcm_ram_addr = s_ready ? base + wr_ptr[AW-1:0] : state == VERIFY ? base + rd_ptr[AW-1:0] : '0;
    itcm_ram_din  = s_ready ? s_data : '0;
    cpu_hold      = state != DONE;
    busy          = state == LOAD || state == VERIFY || state == DRAIN || state == CHECK;
    done          = state == DONE;
    err           = state == ERR;
  end
endmodule

// File: tb/tb_itcm_loader.sv
// tb_itcm_loader: scoreboard bench for itcm_loader with a one-cycle-latency RAM model
module tb_itcm_loader;
  localparam int AW = 8;
  localparam int DW = 16;
  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_cnt = '0;
  logic          verify_en = 0;
  logic          s_valid = 0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, itcm_ram_we, itcm_ram_wem, cpu_hold, busy, done, err;
  logic [AW-1:0] itcm_ram_addr;
  logic [DW-1:0] itcm_ram_din, itcm_ram_dout;
  int total = 0, bad = 0, wr_n = 0;
  logic corrupt = 0;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW+DW-1:0] exp_q [$];
  logic [AW+DW-1:0] e;
  logic [DW-1:0] words [0:3] = '{16'h11, 16'h22, 16'h33, 16'h44};

  itcm_loader #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .verify_en(verify_en), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .itcm_ram_we(itcm_ram_we), .itcm_ram_addr(itcm_ram_addr), .itcm_ram_din(itcm_ram_din),
    .itcm_ram_wem(itcm_ram_wem), .itcm_ram_dout(itcm_ram_dout), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (itcm_ram_we) mem[itcm_ram_addr] <= itcm_ram_din;
    else itcm_ram_dout <= (corrupt && itcm_ram_addr == 8'h12) ? ~mem[itcm_ram_addr] : mem[itcm_ram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (itcm_ram_we) begin
    wr_n++;
    chk("wem", 64'(itcm_ram_wem), 1);
    if (exp_q.size() == 0) chk("unexp_wr", 64'(itcm_ram_addr), 64'hffff_ffff);
    else begin
      e = exp_q.pop_front();
      chk("wr_addr", 64'(itcm_ram_addr), 64'(e[AW+DW-1:DW]));
      chk("wr_data", 64'(itcm_ram_din), 64'(e[DW-1:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] n, input logic v);
    start = 1; base_addr = b; word_cnt = n; verify_en = v;
    tick();
    start = 0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] a);
    s_valid = 1; s_data = d;
    exp_q.push_back({a, d});
    #1 chk("we_hs", 64'(itcm_ram_we), 1);
    tick();
  endtask

  task automatic wait_end();
    for (int k = 0; k < 20 && !(done || err); k++) tick();
  endtask

  task automatic load4(input logic [AW-1:0] b);
    launch(b, 4, 1);
    for (int i = 0; i < 4; i++) send(words[i], b + AW'(i));
    s_valid = 0;
  endtask

  initial begin
    #200000 $display("FAIL watchdog"); $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    chk("rst_hold", 64'(cpu_hold), 1);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_ready", 64'(s_ready), 0);
    chk("rst_we", 64'(itcm_ram_we), 0);
    @(negedge clk) rst = 0;
    tick();
    chk("idle_addr", 64'(itcm_ram_addr), 0);
    // full-rate verified load; done only after N verify + drain + check cycles
    load4(8'h10);
    for (int i = 0; i < 6; i++) begin
      chk("v_done_lo", 64'(done), 0);
      chk("v_hold", 64'(cpu_hold), 1);
      if (i < 4) begin
        chk("rd_addr", 64'(itcm_ram_addr), 64'(8'h10 + i));
        chk("rd_we", 64'(itcm_ram_we), 0);
      end
      tick();
    end
    chk("v_done", 64'(done), 1);
    chk("v_release", 64'(cpu_hold), 0);
    // corrupted readback drives ERR; a clean retry recovers
    corrupt = 1;
    load4(8'h10);
    wait_end();
    chk("c_err", 64'(err), 1);
    chk("c_done", 64'(done), 0);
    chk("c_hold", 64'(cpu_hold), 1);
    corrupt = 0;
    load4(8'h10);
    wait_end();
    chk("r_done", 64'(done), 1);
    chk("r_err", 64'(err), 0);
    // wrapping address, throttled stream, no verify
    launch(8'hff, 3, 0);
    chk("w_hold", 64'(cpu_hold), 1);
    for (int i = 0; i < 3; i++) begin
      send(16'hA0 + DW'(i), 8'hff + AW'(i));
      if (i < 2) begin
        s_valid = 0;
        #1 chk("we_gap", 64'(itcm_ram_we), 0);
        tick();
      end
    end
    s_valid = 0;
    chk("w_done", 64'(done), 1);
    // start during LOAD must not disturb the latched base/count
    launch(8'h40, 3, 0);
    send(16'h0b00, 8'h40);
    s_valid = 0;
    launch(8'h80, 1, 1);
    chk("i_busy", 64'(busy), 1);
    send(16'h0b01, 8'h41);
    chk("i_mid", 64'(done), 0);
    send(16'h0b02, 8'h42);
    s_valid = 0;
    chk("i_done", 64'(done), 1);
    // asynchronous reset mid-load
    launch(8'h20, 5, 0);
    send(16'h0c00, 8'h20);
    s_valid = 1; s_data = 16'h0c01;
    #1 rst = 1;
    #1;
    chk("ar_hold", 64'(cpu_hold), 1);
    chk("ar_ready", 64'(s_ready), 0);
    chk("ar_we", 64'(itcm_ram_we), 0);
    chk("ar_done", 64'(done), 0);
    chk("ar_err", 64'(err), 0);
    chk("ar_busy", 64'(busy), 0);
    s_valid = 0;
    @(negedge clk) rst = 0;
    tick();
    // zero-length load goes straight to DONE with no RAM writes
    begin
      int n0;
      n0 = wr_n;
      launch(8'h30, 0, 1);
      chk("z_done", 64'(done), 1);
      chk("z_busy", 64'(busy), 0);
      tick();
      chk("z_writes", 64'(wr_n), 64'(n0));
    end
    chk("q_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/itcm_loader.md
# itcm_loader

Boot-time writer for the instruction TCM port. It accepts a stream of program words and writes them into ITCM RAM at consecutive addresses. It can then read the image back and compare checksums, and it holds the CPU in reset until the image is loaded and verified. It sits between an external boot/debug source and the ITCM RAM port, ahead of the CPU's fetch path.

## Interface
Parameters:
- AW, `ITCM_RAM_AW: ITCM word-address width
- DW, `ITCM_RAM_DW: ITCM data width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; begins a load. Ignored unless in IDLE, DONE or ERR.
- base_addr  in  AW  first ITCM word address; sampled on accepted start
- word_cnt  in  AW+1  number of words to load; sampled on accepted start
- verify_en  in  1  enables readback check; sampled on accepted start
- s_valid  in  1  stream word valid
- s_data  in  DW  stream word
- s_ready  out  1  stream ready
- itcm_ram_we  out  1  RAM write enable
- itcm_ram_addr  out  AW  RAM word address
- itcm_ram_din  out  DW  RAM write data
- itcm_ram_wem  out  1  RAM write mask; equals itcm_ram_we
- itcm_ram_dout  in  DW  RAM read data; valid one cycle after the address is presented with we=0
- cpu_hold  out  1  holds the CPU in reset while high
- busy  out  1  high while in LOAD, VERIFY, DRAIN or CHECK
- done  out  1  high while in DONE
- err  out  1  high while in ERR

## Operation
- States are IDLE, LOAD, VERIFY, DRAIN, CHECK, DONE and ERR. Reset enters IDLE.
- Values on reset and in IDLE:
  - cpu_hold=1
  - s_ready=0, we=0, busy=0, done=0, err=0
  - addr=0, din=0
  - internal pointers and both checksums are 0
- Accepted start:
  - latches base_addr, word_cnt and verify_en
  - clears wr_ptr, rd_ptr, load_sum and read_sum
  - forces cpu_hold=1
  - moves to LOAD, or to DONE if word_cnt==0
- LOAD:
  - s_ready=1
  - Each handshake (s_valid & s_ready) in the same cycle drives we=wem=1, addr=base+wr_ptr (mod 2^AW) and din=s_data.
  - Each handshake also increments wr_ptr and sets load_sum += s_data (DW bits, wraps).
  - With no handshake, we=0.
  - On the handshake where wr_ptr==word_cnt-1, the next state is VERIFY if verify_en, otherwise DONE.
- VERIFY:
  - s_ready=0, we=0
  - Drives addr=base+rd_ptr (mod 2^AW) and increments rd_ptr every cycle.
  - A registered rd_vld flag marks the returning data, and read_sum += itcm_ram_dout whenever rd_vld=1.
  - After issuing rd_ptr==word_cnt-1, moves to DRAIN.
- DRAIN: one cycle that accumulates the final read word. Then moves to CHECK.
- CHECK: one cycle. Moves to DONE if read_sum==load_sum, otherwise to ERR.
- DONE: cpu_hold=0 and done=1. Stays until an accepted start.
- ERR: err=1 and cpu_hold=1. Stays until an accepted start.
- Address wrap: base+ptr wraps modulo 2^AW with no error. For example, base=2^AW-1 with 2 words writes 2^AW-1, then 0.
- word_cnt > 2^AW is legal; later words overwrite earlier ones. In that case verify compares the sum of what was read back, so ERR can result.
- start in LOAD, VERIFY, DRAIN or CHECK is ignored.
- Reset mid-load aborts immediately: outputs take their IDLE values and RAM contents are undefined. The CPU stays held.

## Timing
- The RAM write is in the same cycle as the stream handshake, so there is zero-cycle write latency.
- At full stream rate, N words occupy N LOAD cycles.
- With verify, DONE or ERR is entered N (VERIFY) + 1 (DRAIN) + 1 (CHECK) cycles after the last LOAD cycle.
- Without verify, DONE is entered the cycle after the last handshake.
- cpu_hold falls in the first DONE cycle. It rises in the cycle after an accepted start.
- s_valid gaps stall LOAD indefinitely, with no timeout.
- All outputs are registered or derived only from state, except s_ready-qualified we/addr/din in LOAD. Those depend combinationally on s_valid.

## Test plan
- Reset, then sample outputs:
  - expected: cpu_hold=1, done=0, err=0, s_ready=0, we=0
  - expected: reset asserted asynchronously mid-LOAD forces these values within the same cycle
- Load with base=0x10, N=4, verify_en=1, full-rate words 0x11,0x22,0x33,0x44:
  - expected: writes to 0x10..0x13 on 4 consecutive cycles
  - expected: 4 reads, then done=1 and cpu_hold=0 exactly 6 cycles after the last write
- Same load as above, but the RAM model corrupts the word at 0x12 on readback:
  - expected: err=1 and cpu_hold stays 1
  - expected: a following start with a correct model reaches DONE
- Load with base=2^AW-1, N=3, verify_en=0, with s_valid toggled every other cycle:
  - expected: writes at 2^AW-1, 0, 1; we high only on handshake cycles
  - expected: done the cycle after the 3rd handshake
- Edge cases:
  - word_cnt=0 start: expected DONE the next cycle with no RAM activity
  - start pulse during LOAD: expected to be ignored, with the latched base and count unchanged
